// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed 7-segment scanner with all-off gaps between slots
// and frame-aligned update of the displayed value.
module seg_scan_ctrl #(
    parameter int DIV = 50000,
    parameter int GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    output logic        ready,
    input  logic        en,
    input  logic        lz_blank,
    output logic [3:0]  hex_digit,
    input  logic [6:0]  seg_dec,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame
);
    localparam int MX = DIV > GAP ? DIV : GAP;
    localparam int CW = MX > 1 ? $clog2(MX) : 1;
    localparam logic [1:0] S_OFF = 2'd0, S_DRIVE = 2'd1, S_GAP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   disp_q, pend_val_q, hi;
    logic          pend_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          drv_end, gap_end, slot_end, blank, commit;

    always_comb begin
        drv_end   = state_q == S_DRIVE && cnt_q == CW'(DIV - 1);
        gap_end   = state_q == S_GAP && cnt_q == CW'(GAP - 1);
        // with no gap configured, the end of DRIVE is the end of the slot
        slot_end  = en && (gap_end || (drv_end && GAP == 0));
        frame     = slot_end && idx_q == 2'd3;
        ready     = ~pend_q;
        hex_digit = disp_q[{idx_q, 2'b00} +: 4];
        hi        = disp_q >> {idx_q, 2'b00};
        blank     = lz_blank && idx_q != 2'd0 && hi == 16'h0;
        commit    = pend_q && (state_q == S_OFF || frame);
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + 1'b1;
        if (!en) begin
            state_d = S_OFF;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else if (state_q == S_OFF) begin
            state_d = S_DRIVE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else if (slot_end) begin
            state_d = S_DRIVE;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
        end else if (drv_end) begin
            state_d = S_GAP;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_OFF;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            disp_q     <= 16'h0;
            pend_val_q <= 16'h0;
            pend_q     <= 1'b0;
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                disp_q <= pend_val_q;
                pend_q <= 1'b0;
            end else if (load && ready) begin
                pend_val_q <= value;
                pend_q     <= 1'b1;
            end
            an_q  <= (state_q == S_DRIVE && !blank) ? ~(4'b0001 << idx_q) : 4'hF;
            seg_q <= (state_q == S_DRIVE && !blank) ? seg_dec : 7'h7F;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: random and directed stimulus against a time-position model of the scanner.
module tb_seg_scan_ctrl;
    localparam int DIV = 4;
    localparam int GAP = 2;
    localparam int P   = DIV + GAP;

    logic        clk, rst, load, en, lz_blank, ready, frame;
    logic [15:0] value;
    logic [3:0]  hex_digit, an;
    logic [6:0]  seg_dec, seg;

    logic [6:0] dec_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    assign seg_dec = dec_t[hex_digit];

    seg_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .ready(ready), .en(en),
        .lz_blank(lz_blank), .hex_digit(hex_digit), .seg_dec(seg_dec), .seg(seg),
        .an(an), .frame(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference: position within the scan since the controller last entered DRIVE
    bit          run, m_pend;
    int          pos;
    logic [15:0] m_disp, m_pv;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        run = 0; pos = 0; m_pend = 0; m_disp = 0; m_pv = 0; m_an = 4'hF; m_seg = 7'h7F;
    endtask

    function automatic int slot_of();
        return run ? (pos / P) % 4 : 0;
    endfunction

    function automatic bit drv_now();
        return run && (pos % P) < DIV;
    endfunction

    task automatic step();
        int slot;
        bit drv, fr, blank;
        logic [3:0] nib;
        #1;
        slot  = slot_of();
        drv   = drv_now();
        fr    = run && en && (pos % P) == P - 1 && slot == 3;
        nib   = m_disp[4*slot +: 4];
        blank = lz_blank && slot > 0 && (m_disp >> (4 * slot)) == 16'h0;
        chk("ready", 16'(ready), 16'(!m_pend));
        chk("hex", 16'(hex_digit), 16'(nib));
        chk("frame", 16'(frame), 16'(fr));
        chk("an", 16'(an), 16'(m_an));
        chk("seg", 16'(seg), 16'(m_seg));
        if (!rst) mreset();
        else begin
            m_an  = (drv && !blank) ? ~(4'b0001 << slot) : 4'hF;
            m_seg = (drv && !blank) ? dec_t[nib] : 7'h7F;
            if (m_pend && (!run || fr)) begin
                m_disp = m_pv;
                m_pend = 0;
            end else if (load && !m_pend) begin
                m_pv   = value;
                m_pend = 1;
            end
            pos = (run && en) ? (pos + 1) % (4 * P) : 0;
            run = en;
        end
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1; load = 0; en = 0; lz_blank = 0; value = 16'h0;
        mreset();
        #2 rst = 0;
        #1;
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_ready", 16'(ready), 16'h1);
        chk("rst_hex", 16'(hex_digit), 16'h0);
        @(negedge clk);
        steps(2);
        rst = 1;
        steps(2);
        load = 1; value = 16'h1234;
        step();
        load = 0;
        chk("ld_busy", 16'(ready), 16'h0);
        steps(3);
        chk("ld_hex", 16'(hex_digit), 16'h4);
        en = 1;
        steps(3);
        chk("dig0_seg", 16'(seg), 16'h19);
        steps(50);
        for (int i = 0; i < 100 && !(run && slot_of() == 1); i++) step();
        chk("sync_idx1", 16'(slot_of()), 16'h1);
        load = 1; value = 16'hABCD;
        step();
        load = 0;
        steps(40);
        lz_blank = 1; load = 1; value = 16'h0050;
        step();
        load = 0;
        steps(60);
        for (int i = 0; i < 20 && !drv_now(); i++) step();
        en = 0;
        steps(2);
        chk("off_an", 16'(an), 16'hF);
        chk("off_seg", 16'(seg), 16'h7F);
        en = 1;
        steps(30);
        load = 1; value = 16'h5A5A;
        for (int i = 0; i < 20 && !(drv_now() && slot_of() < 3); i++) step();
        step();
        load = 0;
        chk("pend_set", 16'(ready), 16'h0);
        #2 rst = 0;
        #1;
        chk("arst_an", 16'(an), 16'hF);
        chk("arst_seg", 16'(seg), 16'h7F);
        chk("arst_ready", 16'(ready), 16'h1);
        chk("arst_hex", 16'(hex_digit), 16'h0);
        chk("arst_frame", 16'(frame), 16'h0);
        mreset();
        step();
        rst = 1;
        steps(30);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) en = ~en;
            if ($urandom_range(99) == 0) lz_blank = ~lz_blank;
            load = $urandom_range(19) == 0;
            case ($urandom_range(3))
                0: value = 16'($urandom);
                1: value = 16'($urandom) & 16'h00FF;
                2: value = 16'($urandom) & 16'h000F;
                default: value = 16'h0;
            endcase
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
